// File: rtl/encoder_n_rr_pkg.sv
// Shared mode codes for the N-to-log2(N) encoder and its bench.
package encoder_n_rr_pkg;

  typedef enum logic [1:0] {
    ENC_LSB    = 2'b00,
    ENC_MSB    = 2'b01,
    ENC_ONEHOT = 2'b10,
    ENC_RR     = 2'b11
  } enc_mode_e;

endpackage

// File: rtl/enc_prio_n.sv
// Combinational LSB-first priority search over an N-bit vector.
module enc_prio_n #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  // Walk downwards so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_n_rr.sv
// N-to-log2(N) encoder with LSB/MSB priority, strict one-hot and round-robin modes,
// registered result and valid/ready handshake on both sides.
module encoder_n_rr
  import encoder_n_rr_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [N-1:0] x,
  input  logic [1:0]   mode,
  output logic         y_valid,
  input  logic         y_ready,
  output logic [W-1:0] y,
  output logic         v,
  output logic         err
);

  enc_mode_e      mode_e;
  logic           accept;
  logic [W-1:0]   ptr_q;
  logic [W-1:0]   start;
  logic [N-1:0]   search_vec;
  logic [2*N-1:0] dbl_vec;
  logic [W-1:0]   idx;
  logic           found;
  logic [W:0]     pop;
  logic [W:0]     rr_sum;
  logic           y_valid_q;
  logic [W-1:0]   y_q, y_d;
  logic           v_q, v_d;
  logic           err_q, err_d;

  assign mode_e  = enc_mode_e'(mode);
  assign x_ready = ~y_valid_q | y_ready;
  assign accept  = x_valid & x_ready;

  // Round-robin search begins one past the last grant, wrapping at N rather than 2^W.
  assign start   = (ptr_q == W'(N - 1)) ? '0 : ptr_q + W'(1);
  assign dbl_vec = {x, x};

  always_comb begin
    search_vec = x;
    case (mode_e)
      ENC_MSB: begin
        for (int i = 0; i < N; i++) begin
          search_vec[i] = x[N-1-i];
        end
      end
      ENC_RR:  search_vec = N'(dbl_vec >> start);
      default: search_vec = x;
    endcase
  end

  enc_prio_n #(.N(N)) u_prio (
    .vec_i   (search_vec),
    .idx_o   (idx),
    .found_o (found)
  );

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + (W + 1)'(x[i]);
    end
  end

  assign rr_sum = {1'b0, idx} + {1'b0, start};

  always_comb begin
    y_d   = idx;
    v_d   = found;
    err_d = 1'b0;
    case (mode_e)
      ENC_MSB: y_d = W'(N - 1) - idx;
      ENC_ONEHOT: begin
        v_d   = (pop == (W + 1)'(1));
        err_d = (pop > (W + 1)'(1));
        y_d   = v_d ? idx : '0;
      end
      ENC_RR:  y_d = (rr_sum >= (W + 1)'(N)) ? W'(rr_sum - (W + 1)'(N)) : W'(rr_sum);
      default: y_d = idx;
    endcase
    // An empty request vector reports "none" in every mode.
    if (!found) begin
      y_d   = '0;
      v_d   = 1'b0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid_q <= 1'b0;
      y_q       <= '0;
      v_q       <= 1'b0;
      err_q     <= 1'b0;
      ptr_q     <= W'(N - 1);
    end else begin
      if (accept) begin
        y_valid_q <= 1'b1;
        y_q       <= y_d;
        v_q       <= v_d;
        err_q     <= err_d;
      end else if (y_ready) begin
        y_valid_q <= 1'b0;
      end
      if (accept && (mode_e == ENC_RR) && found) begin
        ptr_q <= y_d;
      end
    end
  end

  assign y_valid = y_valid_q;
  assign y       = y_q;
  assign v       = v_q;
  assign err     = err_q;

endmodule

// File: tb/tb_encoder_n_rr.sv
// Directed and reference-model checks of encoder_n_rr at N=8 and N=5.
module tb_encoder_n_rr;
  import encoder_n_rr_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       xv8, xr8, yv8, yr8, v8, e8;
  logic [7:0] x8;
  logic [1:0] md8;
  logic [2:0] y8;
  logic       xv5, xr5, yv5, yr5, v5, e5;
  logic [4:0] x5;
  logic [1:0] md5;
  logic [2:0] y5;

  int n_checks = 0;
  int n_fail   = 0;

  bit m_yv[2];
  int m_y[2];
  bit m_v[2];
  bit m_e[2];
  int m_ptr[2];

  always #5 clk = ~clk;

  encoder_n_rr #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .x_valid(xv8), .x_ready(xr8), .x(x8), .mode(md8),
    .y_valid(yv8), .y_ready(yr8), .y(y8), .v(v8), .err(e8)
  );

  encoder_n_rr #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .x_valid(xv5), .x_ready(xr5), .x(x5), .mode(md5),
    .y_valid(yv5), .y_ready(yr5), .y(y5), .v(v5), .err(e5)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input int ey, input bit ev, input bit ee);
    check_eq({tag, "_yv"}, 32'(yv8), 32'd1);
    check_eq({tag, "_y"}, 32'(y8), 32'(ey));
    check_eq({tag, "_v"}, 32'(v8), 32'(ev));
    check_eq({tag, "_err"}, 32'(e8), 32'(ee));
  endtask

  // Independent reference: straightforward search per mode over the low n bits.
  function automatic void ref_enc(input int n, input logic [7:0] xx, input logic [1:0] m,
                                  input int ptr, output int ry, output bit rv,
                                  output bit re, output int nptr);
    int cnt = 0;
    ry = 0; rv = 1'b0; re = 1'b0; nptr = ptr;
    for (int i = 0; i < n; i++) cnt += int'(xx[i]);
    if (cnt != 0) begin
      case (m)
        2'b00: begin
          for (int i = n - 1; i >= 0; i--) if (xx[i]) ry = i;
          rv = 1'b1;
        end
        2'b01: begin
          for (int i = 0; i < n; i++) if (xx[i]) ry = i;
          rv = 1'b1;
        end
        2'b10: begin
          if (cnt == 1) begin
            for (int i = 0; i < n; i++) if (xx[i]) ry = i;
            rv = 1'b1;
          end else begin
            re = 1'b1;
          end
        end
        default: begin
          for (int k = n; k >= 1; k--) if (xx[(ptr + k) % n]) ry = (ptr + k) % n;
          rv   = 1'b1;
          nptr = ry;
        end
      endcase
    end
  endfunction

  task automatic model_step(input int d, input int n, input bit r, input bit xv,
                            input bit yr, input logic [7:0] xx, input logic [1:0] m);
    int ry, np;
    bit rv, re;
    if (r) begin
      m_yv[d] = 1'b0; m_y[d] = 0; m_v[d] = 1'b0; m_e[d] = 1'b0; m_ptr[d] = n - 1;
    end else if (xv && (!m_yv[d] || yr)) begin
      ref_enc(n, xx, m, m_ptr[d], ry, rv, re, np);
      m_yv[d] = 1'b1; m_y[d] = ry; m_v[d] = rv; m_e[d] = re; m_ptr[d] = np;
    end else if (yr) begin
      m_yv[d] = 1'b0;
    end
  endtask

  function automatic logic [7:0] rand_vec(input int n);
    logic [7:0] mask;
    logic [7:0] one;
    int sel;
    mask = 8'((1 << n) - 1);
    one  = 8'd1;
    sel  = int'($urandom_range(0, 3));
    if (sel == 0) return 8'd0;
    if (sel == 1) return one << $urandom_range(0, n - 1);
    return 8'($urandom) & mask;
  endfunction

  initial begin
    rst = 1'b1;
    xv8 = 1'b0; yr8 = 1'b1; x8 = '0; md8 = ENC_LSB;
    xv5 = 1'b0; yr5 = 1'b1; x5 = '0; md5 = ENC_LSB;
    tick();
    check_eq("rst_yv", 32'(yv8), 32'd0);
    check_eq("rst_y", 32'(y8), 32'd0);
    check_eq("rst_v", 32'(v8), 32'd0);
    check_eq("rst_err", 32'(e8), 32'd0);
    check_eq("rst_xr", 32'(xr8), 32'd1);
    rst = 1'b0;

    xv8 = 1'b1; md8 = ENC_LSB; x8 = 8'b0110_1000; tick(); chk8("lsb", 3, 1, 0);
    md8 = ENC_MSB; tick(); chk8("msb", 6, 1, 0);
    md8 = ENC_ONEHOT; x8 = 8'b0001_0000; tick(); chk8("oh1", 4, 1, 0);
    x8 = 8'b0001_0100; tick(); chk8("oh2", 0, 0, 1);
    x8 = 8'd0;
    for (int m = 0; m < 4; m++) begin
      md8 = 2'(m); tick(); chk8($sformatf("zero_m%0d", m), 0, 0, 0);
    end

    md8 = ENC_RR; x8 = 8'b1000_0101;
    tick(); chk8("rr0", 0, 1, 0);
    tick(); chk8("rr1", 2, 1, 0);
    x8 = 8'd0; tick(); chk8("rr_zero", 0, 0, 0);
    x8 = 8'b1000_0101;
    tick(); chk8("rr2", 7, 1, 0);
    tick(); chk8("rr3_wrap", 0, 1, 0);

    xv8 = 1'b0; tick();
    check_eq("drain_yv", 32'(yv8), 32'd0);
    yr8 = 1'b0; xv8 = 1'b1; md8 = ENC_LSB; x8 = 8'b0000_0110;
    tick(); chk8("bp_first", 1, 1, 0);
    check_eq("bp_xr", 32'(xr8), 32'd0);
    x8 = 8'b0010_0000;
    for (int c = 0; c < 3; c++) begin
      tick(); chk8($sformatf("bp_hold%0d", c), 1, 1, 0);
      check_eq("bp_xr_hold", 32'(xr8), 32'd0);
    end
    yr8 = 1'b1; #1;
    check_eq("bp_xr_release", 32'(xr8), 32'd1);
    tick(); chk8("bp_next", 5, 1, 0);

    md8 = ENC_RR; x8 = 8'b1000_0101; tick(); chk8("pre_rst_rr", 2, 1, 0);
    xv8 = 1'b0; yr8 = 1'b0; tick(); chk8("pre_rst_hold", 2, 1, 0);
    rst = 1'b1; tick();
    check_eq("mid_rst_yv", 32'(yv8), 32'd0);
    check_eq("mid_rst_y", 32'(y8), 32'd0);
    check_eq("mid_rst_v", 32'(v8), 32'd0);
    check_eq("mid_rst_err", 32'(e8), 32'd0);
    rst = 1'b0; xv8 = 1'b1; yr8 = 1'b1; tick(); chk8("post_rst_rr", 0, 1, 0);
    xv8 = 1'b0;

    xv5 = 1'b1; md5 = ENC_RR; x5 = 5'b10001;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("n5_rr%0d", k), 32'(y5), (k == 1) ? 32'd4 : 32'd0);
      check_eq("n5_rr_v", 32'(v5), 32'd1);
    end
    md5 = ENC_MSB; x5 = 5'b11111; tick();
    check_eq("n5_msb", 32'(y5), 32'd4);
    md5 = ENC_LSB; x5 = 5'b10000; tick();
    check_eq("n5_lsb_top", 32'(y5), 32'd4);

    rst = 1'b1;
    model_step(0, 8, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
    model_step(1, 5, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
    tick();
    for (int c = 0; c < 10000; c++) begin
      check_eq("r8_yv", 32'(yv8), 32'(m_yv[0]));
      if (m_yv[0]) begin
        check_eq("r8_y", 32'(y8), 32'(m_y[0]));
        check_eq("r8_v", 32'(v8), 32'(m_v[0]));
        check_eq("r8_err", 32'(e8), 32'(m_e[0]));
      end
      check_eq("r5_yv", 32'(yv5), 32'(m_yv[1]));
      if (m_yv[1]) begin
        check_eq("r5_y", 32'(y5), 32'(m_y[1]));
        check_eq("r5_v", 32'(v5), 32'(m_v[1]));
        check_eq("r5_err", 32'(e5), 32'(m_e[1]));
      end
      rst = ($urandom_range(0, 199) == 0);
      xv8 = ($urandom_range(0, 3) != 0); yr8 = ($urandom_range(0, 3) != 0);
      x8  = rand_vec(8); md8 = 2'($urandom_range(0, 3));
      xv5 = ($urandom_range(0, 3) != 0); yr5 = ($urandom_range(0, 3) != 0);
      x5  = 5'(rand_vec(5)); md5 = 2'($urandom_range(0, 3));
      #1;
      check_eq("r8_xr", 32'(xr8), 32'(!m_yv[0] || yr8));
      check_eq("r5_xr", 32'(xr5), 32'(!m_yv[1] || yr5));
      model_step(0, 8, rst, xv8, yr8, x8, md8);
      model_step(1, 5, rst, xv5, yr5, {3'b000, x5}, md5);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
